// File: rtl/par2ser_tx_if.sv
// Parallel-side bus of the serial frame transmitter: word handshake plus line and status outputs.
// The master side produces words; the slave side (the transmitter) drives the line.
interface par2ser_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             tx_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  tx_out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output tx_out,
    output busy,
    output done
  );
endinterface

// File: rtl/par2ser_tx.sv
// Parallel-to-serial frame transmitter: start(0), data LSB-first, optional even parity, stop(1).
// Every line bit is held for DIV clocks; all outputs come straight from flops.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line high, ready for a word; first cycle after STOP pulses done
// S_START  | start bit (0)
// S_DATA   | data bit shift_q[0]; idx_q counts the bits already sent
// S_PARITY | even parity of the latched word (only when PARITY_EN != 0)
// S_STOP   | stop bit (1); last cycle returns to IDLE
module par2ser_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic         C,
  input  logic         R,
  par2ser_tx_if.slave  bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic div_last;
  logic idx_last;
  logic accept;

  assign div_last = (div_q == DIV_W'(DIV - 1));
  assign idx_last = (idx_q == IDX_W'(WIDTH - 1));
  assign accept   = bus.valid_in & ready_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = bus.data_in;
          par_d   = ^bus.data_in;
          div_d   = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (div_last) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_last) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_STOP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (div_last) begin
          div_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        div_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it in the same cycle.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_out    = tx_q;
  assign bus.ready_out = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_par2ser_tx.sv
// Bench for par2ser_tx: DUT A (DIV=4, parity on) and DUT B (DIV=1, parity off) share clock and reset.
// Expected line bits are queued per clock when a word is offered and popped as the frame plays out.
module tb_par2ser_tx;

  logic C = 1'b0;
  logic R = 1'b1;
  always #5 C = ~C;

  par2ser_tx_if #(.WIDTH(8)) ia ();
  par2ser_tx_if #(.WIDTH(8)) ib ();

  par2ser_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(1)) dut_a (.C(C), .R(R), .bus(ia.slave));
  par2ser_tx #(.WIDTH(8), .DIV(1), .PARITY_EN(0)) dut_b (.C(C), .R(R), .bus(ib.slave));

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  bit qa[$];
  bit qb[$];

  task automatic tick();
    @(posedge C);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {tx_out, ready_out, busy, done}
  function automatic logic [3:0] outs(input bit sel);
    if (sel) return {ib.tx_out, ib.ready_out, ib.busy, ib.done};
    return {ia.tx_out, ia.ready_out, ia.busy, ia.done};
  endfunction

  task automatic push_frame(input bit sel, input logic [7:0] word);
    int  div;
    bit  pen;
    bit  seq[$];
    div = sel ? 1 : 4;
    pen = sel ? 1'b0 : 1'b1;
    seq.push_back(1'b0);
    for (int b = 0; b < 8; b++) seq.push_back(word[b]);
    if (pen) seq.push_back(^word);
    seq.push_back(1'b1);
    foreach (seq[k])
      for (int d = 0; d < div; d++)
        if (sel) qb.push_back(seq[k]); else qa.push_back(seq[k]);
  endtask

  task automatic chk_idle(input bit sel, input string tag, input bit exp_done);
    logic [3:0] o;
    o = outs(sel);
    chk({tag, ".tx"},    32'(o[3]), 32'd1);
    chk({tag, ".ready"}, 32'(o[2]), 32'd1);
    chk({tag, ".busy"},  32'(o[1]), 32'd0);
    chk({tag, ".done"},  32'(o[0]), 32'(exp_done));
  endtask

  task automatic frame_cycle(input bit sel, input string tag);
    logic [3:0] o;
    bit         e;
    e = sel ? qb.pop_front() : qa.pop_front();
    o = outs(sel);
    chk({tag, ".tx"},    32'(o[3]), 32'(e));
    chk({tag, ".ready"}, 32'(o[2]), 32'd0);
    chk({tag, ".busy"},  32'(o[1]), 32'd1);
    chk({tag, ".done"},  32'(o[0]), 32'd0);
  endtask

  // Send one word through DUT A; optionally poke valid_in/data_in mid-frame.
  task automatic send_a(input logic [7:0] word, input int glitch_at, input string tag,
                        output int busy_cnt, output logic par_seen);
    int n;
    ia.data_in  = word;
    ia.valid_in = 1'b1;
    push_frame(1'b0, word);
    n = qa.size();
    tick();
    ia.valid_in = 1'b0;
    ia.data_in  = 8'($urandom);
    busy_cnt = 0;
    par_seen = 1'bx;
    for (int i = 0; i < n; i++) begin
      if (i == glitch_at) begin
        ia.valid_in = 1'b1;
        ia.data_in  = 8'h3C;
      end else if (i == glitch_at + 1) begin
        ia.valid_in = 1'b0;
      end
      if (i == 36) par_seen = ia.tx_out;
      busy_cnt += int'(ia.busy);
      frame_cycle(1'b0, tag);
      tick();
    end
    chk_idle(1'b0, {tag, "_donecyc"}, 1'b1);
    tick();
    chk_idle(1'b0, {tag, "_after"}, 1'b0);
  endtask

  initial begin
    int   bc;
    logic ps;
    int   t1;

    ia.valid_in = 1'b0; ia.data_in = '0;
    ib.valid_in = 1'b0; ib.data_in = '0;

    // 1: reset held two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      ia.valid_in = 1'($urandom_range(0, 1)); ia.data_in = 8'($urandom);
      ib.valid_in = 1'($urandom_range(0, 1)); ib.data_in = 8'($urandom);
      tick();
      chk_idle(1'b0, "rst_a", 1'b0);
      chk_idle(1'b1, "rst_b", 1'b0);
    end
    R = 1'b0;
    ia.valid_in = 1'b0;
    ib.valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle(1'b0, "post_rst_a", 1'b0);
      chk_idle(1'b1, "post_rst_b", 1'b0);
    end

    // 2: 8'hA5 with parity, DIV=4
    send_a(8'hA5, -1, "a5", bc, ps);
    chk("a5_busy_cycles", 32'(bc), 32'd44);
    chk("a5_parity", 32'(ps), 32'd0);

    // 3: DIV=1, no parity, 8'hFF then 8'h00 with valid_in held
    ib.data_in  = 8'hFF;
    ib.valid_in = 1'b1;
    push_frame(1'b1, 8'hFF);
    tick();
    ib.data_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      frame_cycle(1'b1, "ff");
      tick();
    end
    chk_idle(1'b1, "ff_donecyc", 1'b1);
    t1 = cyc;
    push_frame(1'b1, 8'h00);
    tick();
    ib.valid_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      frame_cycle(1'b1, "00");
      tick();
    end
    chk_idle(1'b1, "00_donecyc", 1'b1);
    chk("b2b_done_gap", 32'(cyc - t1), 32'd11);
    tick();
    chk_idle(1'b1, "00_after", 1'b0);

    // 4: valid pulse with 8'h3C in the middle of an 8'h81 frame is ignored
    send_a(8'h81, 20, "x81", bc, ps);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_idle(1'b0, "x81_quiet", 1'b0);
    end

    // 5: reset during data bit 3 of 8'hF0, then 8'h0F goes out cleanly
    ia.data_in  = 8'hF0;
    ia.valid_in = 1'b1;
    push_frame(1'b0, 8'hF0);
    tick();
    ia.valid_in = 1'b0;
    for (int i = 0; i < 18; i++) begin
      frame_cycle(1'b0, "f0");
      if (i < 17) tick();
    end
    R = 1'b1;
    tick();
    R = 1'b0;
    qa.delete();
    chk_idle(1'b0, "f0_rst", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle(1'b0, "f0_nodone", 1'b0);
    end
    send_a(8'h0F, -1, "x0f", bc, ps);
    chk("x0f_busy_cycles", 32'(bc), 32'd44);

    // 6: parity bit values
    send_a(8'h01, -1, "x01", bc, ps);
    chk("x01_parity", 32'(ps), 32'd1);
    send_a(8'h03, -1, "x03", bc, ps);
    chk("x03_parity", 32'(ps), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
